// File: rtl/irq_priority_queue.sv
// Request capture and sequencing ahead of the priority encoder. Rising edges on req
// become sticky pending events. The highest unmasked pending bit is handed out over valid/ready.
module irq_priority_queue #(
  parameter int unsigned N  = 8,
  parameter int unsigned CW = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  req,
  input  logic          mask_wr,
  input  logic [N-1:0]  mask_in,
  output logic [CW-1:0] code,
  output logic          valid,
  input  logic          ready,
  output logic          any_pend,
  output logic [CW:0]   pend_cnt,
  output logic          ovf,
  input  logic          ovf_clr
);

  typedef enum logic {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [N-1:0]  req_q;
  logic [N-1:0]  pending;
  logic [N-1:0]  mask;
  logic [N-1:0]  rise;
  logic [N-1:0]  clr;
  logic [N-1:0]  pend_nxt;
  logic [N-1:0]  eligible;
  logic [CW-1:0] sel_code;
  logic [CW-1:0] code_nxt;
  logic          valid_nxt;
  logic          ovf_set;
  logic          ovf_nxt;
  logic [CW:0]   cnt_nxt;

  // Event capture: a set on the same edge as a clear re-queues the event
  always_comb begin
    rise = req & ~req_q;
    clr  = '0;
    if (valid && ready) begin
      clr = N'(1) << code;
    end
    pend_nxt = (pending & ~clr) | rise;
    ovf_set  = |(rise & pending & ~clr);
    ovf_nxt  = ovf;
    if (ovf_clr) begin
      ovf_nxt = 1'b0;
    end
    if (ovf_set) begin
      ovf_nxt = 1'b1;
    end
  end

  // Highest-index eligible bit wins; ascending scan lets the last hit stick
  always_comb begin
    eligible = pending & ~mask;
    sel_code = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (eligible[i]) begin
        sel_code = CW'(i);
      end
    end
  end

  always_comb begin
    cnt_nxt = '0;
    for (int unsigned i = 0; i < N; i++) begin
      cnt_nxt = cnt_nxt + (CW+1)'(pend_nxt[i]);
    end
  end

  // Next-state and presented-code logic; code stays frozen while presenting
  always_comb begin
    state_nxt = state;
    code_nxt  = code;
    valid_nxt = valid;
    case (state)
      IDLE: begin
        valid_nxt = 1'b0;
        if (|eligible) begin
          code_nxt  = sel_code;
          valid_nxt = 1'b1;
          state_nxt = PRESENT;
        end
      end
      PRESENT: begin
        if (ready) begin
          valid_nxt = 1'b0;
          state_nxt = IDLE;
        end
      end
      default: begin
        valid_nxt = 1'b0;
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // req_q resets high so lines held through reset need a fresh rise
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      req_q    <= '1;
      pending  <= '0;
      mask     <= '0;
      code     <= '0;
      valid    <= 1'b0;
      ovf      <= 1'b0;
      any_pend <= 1'b0;
      pend_cnt <= '0;
    end else begin
      req_q    <= req;
      pending  <= pend_nxt;
      if (mask_wr) begin
        mask <= mask_in;
      end
      code     <= code_nxt;
      valid    <= valid_nxt;
      ovf      <= ovf_nxt;
      any_pend <= |pend_nxt;
      pend_cnt <= cnt_nxt;
    end
  end

endmodule
